// File: rtl/multiplicador_sequencial.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or two's complement.
// One WIDTH+1 bit adder, WIDTH CALC cycles plus one FIX cycle for sign restoration.
module multiplicador_sequencial #(
    parameter int WIDTH = 5
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_en,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Negating -2^(WIDTH-1) wraps to the same bit pattern, which read unsigned is its magnitude.
        mag_a = (signed_en && a[WIDTH-1]) ? -a : a;
        mag_b = (signed_en && b[WIDTH-1]) ? -b : b;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    sign_d   = signed_en & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
            end
            FIX: begin
                product_d = sign_q ? -acc_q : acc_q;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = done_q;
        product = product_q;
    end

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Scoreboard bench for multiplicador_sequencial (WIDTH=5 and WIDTH=8 instances).
// Stimulus pushes {product, due cycle}; per-instance monitors pop on every done pulse.
module tb_multiplicador_sequencial;

    typedef struct {
        logic [15:0] p;
        int unsigned due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start5, sen5, busy5, done5;
    logic [4:0]  a5, b5;
    logic [9:0]  product5;
    logic        start8, sen8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int unsigned cyc;
    int          checks;
    int          errors;
    exp_t        sb5[$];
    exp_t        sb8[$];

    multiplicador_sequencial #(.WIDTH(5)) dut5 (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start5),
        .signed_en(sen5),
        .a        (a5),
        .b        (b5),
        .busy     (busy5),
        .done     (done5),
        .product  (product5)
    );

    multiplicador_sequencial #(.WIDTH(8)) dut8 (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start8),
        .signed_en(sen8),
        .a        (a8),
        .b        (b8),
        .busy     (busy8),
        .done     (done8),
        .product  (product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done5 === 1'b1) begin
            if (sb5.size() == 0) begin
                chk("w5_unexpected_done", 1, 0);
            end else begin
                e = sb5.pop_front();
                chk("w5_product", product5, e.p);
                chk("w5_done_cycle", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (sb8.size() == 0) begin
                chk("w8_unexpected_done", 1, 0);
            end else begin
                e = sb8.pop_front();
                chk("w8_product", product8, e.p);
                chk("w8_done_cycle", cyc, e.due);
            end
        end
    end

    // Called #1 after an edge with the DUT idle; returns #1 after the done edge.
    task automatic issue5(input logic s, input logic [4:0] x, input logic [4:0] y,
                          input logic [15:0] p);
        start5 = 1'b1; sen5 = s; a5 = x; b5 = y;
        @(posedge clk); #1;
        sb5.push_back('{p, cyc + 6});
        start5 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic issue8(input logic s, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] p);
        start8 = 1'b1; sen8 = s; a8 = x; b8 = y;
        @(posedge clk); #1;
        sb8.push_back('{p, cyc + 9});
        start8 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start5 = 1'b0; sen5 = 1'b0; a5 = '0; b5 = '0;
        start8 = 1'b0; sen8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", busy5, 0);
        chk("reset_done", done5, 0);
        chk("reset_product", product5, 0);
        chk("reset_product8", product8, 0);

        // 31*31 unsigned with busy profile: high for 6 cycles after the accept edge
        start5 = 1'b1; sen5 = 1'b0; a5 = 5'd31; b5 = 5'd31;
        @(posedge clk); #1;
        sb5.push_back('{16'd961, cyc + 6});
        start5 = 1'b0;
        chk("busy_after_accept", busy5, 1);
        for (int i = 1; i < 6; i++) begin
            @(posedge clk); #1;
            chk("busy_calc_fix", busy5, 1);
        end
        @(posedge clk); #1;
        chk("busy_clear_at_done", busy5, 0);

        issue5(1'b1, 5'h10, 5'h10, 16'h100);
        issue5(1'b1, 5'h10, 5'h0F, 16'h310);
        issue5(1'b0, 5'd0,  5'd27, 16'd0);
        issue5(1'b1, 5'h1D, 5'd0,  16'd0);

        // second start two cycles into the operation must be dropped
        start5 = 1'b1; sen5 = 1'b0; a5 = 5'd7; b5 = 5'd9;
        @(posedge clk); #1;
        sb5.push_back('{16'd63, cyc + 6});
        start5 = 1'b0;
        @(posedge clk); #1;
        start5 = 1'b1; sen5 = 1'b1; a5 = 5'd1; b5 = 5'd1;
        @(posedge clk); #1;
        start5 = 1'b0;
        chk("busy_ignored_start", busy5, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("product_held", product5, 63);

        // reset in the third CALC cycle discards the operation
        start5 = 1'b1; sen5 = 1'b0; a5 = 5'd21; b5 = 5'd19;
        @(posedge clk); #1;
        start5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("no_intermediate_product", product5, 63);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midop_reset_busy", busy5, 0);
        chk("midop_reset_done", done5, 0);
        chk("midop_reset_product", product5, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_reset", product5, 0);
        issue5(1'b0, 5'd13, 5'd11, 16'd143);

        // start held high: each op re-accepted in the IDLE cycle that shows done
        start5 = 1'b1; sen5 = 1'b1; a5 = 5'h1F; b5 = 5'h1F;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            sb5.push_back('{16'd1, cyc + 6});
            repeat (6) @(posedge clk);
            #1;
        end
        start5 = 1'b0;

        issue8(1'b0, 8'd255, 8'd255, 16'd65025);
        issue8(1'b1, 8'h80,  8'h80,  16'h4000);
        issue8(1'b1, 8'h80,  8'h7F,  16'hC080);

        repeat (3) @(posedge clk);
        #1;
        chk("w5_pending", sb5.size(), 0);
        chk("w8_pending", sb8.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
